// File: rtl/spart_pkg.sv
// ============================================================================
//  Module   : spart_pkg
//  Purpose  : Shared constants, FSM state types and helpers for the SPART UART.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIVLO  = 2'b10;
    localparam logic [1:0] ADDR_DIVHI  = 2'b11;

    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;

    localparam logic [15:0] DEFAULT_DIVISOR = 16'd5207;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Divisors below 2 are clamped so the half-bit wait is never zero length.
    function automatic logic [15:0] eff_divisor(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spart_rx.sv
// ============================================================================
//  Module   : spart_rx
//  Purpose  : 8N1 receiver: rxd synchronizer, start/data/stop FSM, rx buffer, rda.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_rx
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rxd,
    input  logic [15:0] i_eff_div,
    input  logic        i_buf_rd,
    output logic [7:0]  o_rx_data,
    output logic        o_rda
);

    logic [1:0]  r_sync;
    logic        r_rx_prev;
    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bits;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;
    logic        r_rda;

    logic        w_rx;
    logic        w_fall;
    logic [15:0] w_half_m1;
    logic        w_load;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;
    // Half a bit period is (div+1)/2 clocks; the counter runs down to zero inclusive.
    assign w_half_m1 = {1'b0, i_eff_div[15:1]} + {15'd0, i_eff_div[0]} - 16'd1;
    assign w_load    = (r_state == RX_STOP) && (r_cnt == 16'd0) && w_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_rxd};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= 16'd0;
            r_bits  <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= w_half_m1;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!w_rx) begin
                        r_cnt   <= i_eff_div;
                        r_bits  <= 3'd0;
                        r_state <= RX_DATA;
                    end else begin
                        r_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= i_eff_div;
                        r_bits  <= r_bits + 3'd1;
                        if (r_bits == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    // A load in the same cycle as a buffer read keeps rda set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= 8'h00;
            r_rda <= 1'b0;
        end else if (w_load) begin
            r_buf <= r_shift;
            r_rda <= 1'b1;
        end else if (i_buf_rd) begin
            r_rda <= 1'b0;
        end
    end

    assign o_rx_data = r_buf;
    assign o_rda     = r_rda;

endmodule

`default_nettype wire

// File: rtl/spart_core.sv
// ============================================================================
//  Module   : spart_core
//  Purpose  : 8N1 UART with 4-register bus port, programmable baud divisor and
//             transmitter. Define SPART_STATUS_REG_EN to expose status at 01.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spart_core
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIVISOR = spart_pkg::DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic [15:0] r_divisor;
    tx_state_t   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [8:0]  r_tx_shift;
    logic [3:0]  r_tx_bits;
    logic        r_txd;

    logic        w_wr;
    logic        w_rd;
    logic [15:0] w_eff_div;
    logic        w_tx_load;
    logic        w_buf_rd;
    logic [7:0]  w_rx_data;
    logic        w_rd_en;
    logic [7:0]  w_rd_data;

    assign w_wr      = iocs & ~iorw;
    assign w_rd      = iocs & iorw;
    assign w_eff_div = eff_divisor(r_divisor);
    assign w_tx_load = w_wr && (ioaddr == ADDR_BUF) && (r_tx_state == TX_IDLE);
    assign w_buf_rd  = w_rd && (ioaddr == ADDR_BUF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divisor <= DEFAULT_DIVISOR;
        end else if (w_wr && (ioaddr == ADDR_DIVLO)) begin
            r_divisor[7:0] <= databus;
        end else if (w_wr && (ioaddr == ADDR_DIVHI)) begin
            r_divisor[15:8] <= databus;
        end
    end

    // Shift register holds {stop, data}; each bit boundary emits bit 0 and
    // refills with 1 so the stop level falls out after the eighth data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_shift <= 9'h1FF;
            r_tx_bits  <= 4'd0;
            r_txd      <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            if (w_tx_load) begin
                r_tx_shift <= {1'b1, databus};
                r_tx_cnt   <= w_eff_div;
                r_tx_bits  <= 4'd0;
                r_txd      <= 1'b0;
                r_tx_state <= TX_START;
            end
        end else if (r_tx_cnt != 16'd0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
        end else begin
            r_tx_cnt <= w_eff_div;
            case (r_tx_state)
                TX_START, TX_DATA: begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bits  <= r_tx_bits + 4'd1;
                    if (r_tx_state == TX_START) begin
                        r_tx_state <= TX_DATA;
                    end else if (r_tx_bits == 4'd8) begin
                        r_tx_state <= TX_STOP;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign txd = r_txd;
    assign tbr = (r_tx_state == TX_IDLE);

    spart_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .i_rxd     (rxd),
        .i_eff_div (w_eff_div),
        .i_buf_rd  (w_buf_rd),
        .o_rx_data (w_rx_data),
        .o_rda     (rda)
    );

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_data = 8'h00;
        if (w_rd) begin
            case (ioaddr)
                ADDR_BUF: begin
                    w_rd_en   = 1'b1;
                    w_rd_data = w_rx_data;
                end
`ifdef SPART_STATUS_REG_EN
                ADDR_STATUS: begin
                    w_rd_en             = 1'b1;
                    w_rd_data[STAT_RDA] = rda;
                    w_rd_data[STAT_TBR] = tbr;
                end
`endif
                default: ;
            endcase
        end
    end

    assign databus = w_rd_en ? w_rd_data : 8'bz;

endmodule

`default_nettype wire

// File: tb/tb_spart_core.sv
// ============================================================================
//  Module   : tb_spart_core
//  Purpose  : Self-checking bench for spart_core (loopback and direct rxd drive).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spart_core;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;
    logic       tb_rxd;
    logic       loop;
    logic [7:0] tb_dout;
    logic       tb_drv;

    int total = 0;
    int bad   = 0;

    assign databus = tb_drv ? tb_dout : 8'bz;
    assign rxd     = loop ? txd : tb_rxd;

    always #5 clk = ~clk;

    spart_core dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial line level of an 8N1 frame at bit position idx (0 = start).
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return d[idx-1];
    endfunction

    function automatic int period_of(input int div);
        return ((div < 2) ? 2 : div) + 1;
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dout = d; tb_drv = 1'b1;
        @(posedge clk); #1;
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    // The bench holds databus at 0; any DUT drive shows up as a changed value.
    task automatic check_z(input string tag, input logic sel, input logic [1:0] a);
        tb_dout = 8'h00; tb_drv = 1'b1;
        iocs = sel; iorw = 1'b1; ioaddr = a;
        #1 chk(tag, {24'd0, databus}, 32'h0);
        @(posedge clk); #1;
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic set_div(input int div);
        bus_write(ADDR_DIVLO, div[7:0]);
        bus_write(ADDR_DIVHI, div[15:8]);
    endtask

    // Sends d and checks txd/tbr every cycle of the frame; an extra buffer
    // write is attempted at cycle wr_at (negative = none).
    task automatic send_and_check(input logic [7:0] d, input int p, input int wr_at);
        int errs;
        errs = 0;
        bus_write(ADDR_BUF, d);
        for (int k = 0; k < 10 * p; k++) begin
            if (txd !== frame_bit(d, k / p) || tbr !== 1'b0) errs++;
            if (k == wr_at) begin
                iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_BUF; tb_dout = 8'hAA; tb_drv = 1'b1;
            end
            @(posedge clk); #1;
            iocs = 1'b0; tb_drv = 1'b0;
        end
        chk("tx_frame_errs", errs, 0);
        chk("tbr_after_frame", {31'd0, tbr}, 1);
        chk("txd_after_frame", {31'd0, txd}, 1);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] d);
        logic [7:0] v;
        repeat (4) @(posedge clk);
        #1 chk({tag, "_rda"}, {31'd0, rda}, 1);
        bus_read(ADDR_BUF, v);
        chk({tag, "_data"}, {24'd0, v}, {24'd0, d});
        chk({tag, "_rda_clr"}, {31'd0, rda}, 0);
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop, input int p);
        for (int k = 0; k < 10; k++) begin
            tb_rxd = (k == 9) ? stop : frame_bit(d, k);
            repeat (p) @(posedge clk);
            #1;
        end
        tb_rxd = 1'b1;
        repeat (2 * p) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] d1;
        logic [7:0] d2;
        int         n;
        int         div;
        int         errs;

        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        tb_dout = 8'h00; tb_drv = 1'b0; tb_rxd = 1'b1; loop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", {31'd0, txd}, 1);
        chk("reset_tbr", {31'd0, tbr}, 1);
        chk("reset_rda", {31'd0, rda}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_z("idle_bus_z", 1'b0, ADDR_BUF);
`ifdef SPART_STATUS_REG_EN
        bus_read(ADDR_STATUS, v);
        chk("status_reset", {24'd0, v}, 32'h02);
`else
        check_z("status_z", 1'b1, ADDR_STATUS);
`endif
        check_z("divlo_read_z", 1'b1, ADDR_DIVLO);
        check_z("divhi_read_z", 1'b1, ADDR_DIVHI);

        // Default divisor: start bit length, then reset mid-frame.
        bus_write(ADDR_BUF, 8'hA5);
        n = 0;
        while (txd === 1'b0 && n < 6000) begin
            n++;
            @(posedge clk); #1;
        end
        chk("default_start_len", n, 5208);
        chk("default_tbr_busy", {31'd0, tbr}, 0);
        rst = 1'b1;
        #1;
        chk("midrst_txd", {31'd0, txd}, 1);
        chk("midrst_tbr", {31'd0, tbr}, 1);
        chk("midrst_rda", {31'd0, rda}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Loopback frame after reset with divisor 7 (8 clocks per bit).
        set_div(7);
        send_and_check(8'h46, 8, -1);
        repeat (4) @(posedge clk);
        #1;
`ifdef SPART_STATUS_REG_EN
        bus_read(ADDR_STATUS, v);
        chk("status_rx_ready", {24'd0, v}, 32'h03);
`endif
        expect_rx("loop46", 8'h46);

        // Write while busy: frame unchanged, no second frame follows.
        send_and_check(8'h3C, 8, 25);
        errs = 0;
        for (int k = 0; k < 24; k++) begin
            if (txd !== 1'b1 || tbr !== 1'b1) errs++;
            @(posedge clk); #1;
        end
        chk("no_second_frame", errs, 0);
        expect_rx("busy3C", 8'h3C);

        // Divisor 0 and 1 behave as 2.
        for (int i = 0; i < 2; i++) begin
            d1 = 8'($urandom);
            set_div(i);
            send_and_check(d1, period_of(i), -1);
            expect_rx("div_small", d1);
        end

        // Random divisors and data through the loopback.
        for (int i = 0; i < 10; i++) begin
            div = int'($urandom_range(2, 12));
            d1  = 8'($urandom);
            set_div(div);
            send_and_check(d1, period_of(div), -1);
            expect_rx("rand_loop", d1);
        end

        // Unread byte overwritten by the next one; rda stays set.
        set_div(5);
        d1 = 8'($urandom);
        d2 = ~d1;
        send_and_check(d1, 6, -1);
        send_and_check(d2, 6, -1);
        expect_rx("overwrite", d2);

        // Direct rxd drive: framing error, glitch, then a good frame.
        loop = 1'b0;
        set_div(7);
        drive_rx_frame(8'h5A, 1'b0, 8);
        chk("framing_err_rda", {31'd0, rda}, 0);
        tb_rxd = 1'b0;
        @(posedge clk); #1;
        tb_rxd = 1'b1;
        repeat (24) @(posedge clk);
        #1 chk("glitch_rda", {31'd0, rda}, 0);
        d1 = 8'($urandom);
        drive_rx_frame(d1, 1'b1, 8);
        expect_rx("direct_rx", d1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
